// File: rtl/lcd_hex_sequencer.sv
// lcd_hex_sequencer
//   Drives a 16x2 HD44780-style character LCD in write-only mode. After reset
//   it waits for the panel to power up, runs the four-command init sequence,
//   then shows each accepted 32-bit word as 8 uppercase hex characters at the
//   start of line 1. All bus timing (EN pulse width, settle times) lives here.
//
// Ports
//   clk, reset      : system clock, synchronous active-high reset
//   msg_valid/_data : display request; accepted whenever msg_ready is high
//   msg_ready       : equals init_done
//   busy            : high while initialising or writing a message
//   init_done       : init sequence complete, sticky until reset
//   LCD_DATA/RS/RW/EN : LCD bus (RW tied 0)
//   dbg_state       : current top-level FSM state, for observation only
//
// Handshake: a request transfers on any cycle where msg_valid && msg_ready.
// There is no back-pressure after init; while a message is being written,
// accepted requests land in a one-deep pending buffer (last value wins).
module lcd_hex_sequencer #(
  parameter int         EN_HIGH_CYC   = 16,
  parameter int         CMD_WAIT_CYC  = 2000,
  parameter int         CLR_WAIT_CYC  = 82000,
  parameter int         INIT_WAIT_CYC = 1000000,
  parameter logic [7:0] LINE_ADDR     = 8'h80
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        msg_valid,
  input  logic [31:0] msg_data,
  output logic        msg_ready,
  output logic        busy,
  output logic        init_done,
  output logic [7:0]  LCD_DATA,
  output logic        LCD_RW,
  output logic        LCD_EN,
  output logic        LCD_RS,
  output logic [2:0]  dbg_state
);

  localparam logic [2:0] ST_PWR_WAIT = 3'd0;
  localparam logic [2:0] ST_INIT     = 3'd1;
  localparam logic [2:0] ST_IDLE     = 3'd2;
  localparam logic [2:0] ST_ADDR     = 3'd3;
  localparam logic [2:0] ST_CHAR     = 3'd4;

  localparam logic [1:0] PH_SETUP = 2'd0;
  localparam logic [1:0] PH_PULSE = 2'd1;
  localparam logic [1:0] PH_WAIT  = 2'd2;

  localparam logic [31:0] EN_LAST   = 32'(EN_HIGH_CYC - 1);
  localparam logic [31:0] CMD_LAST  = 32'(CMD_WAIT_CYC - 1);
  localparam logic [31:0] CLR_LAST  = 32'(CLR_WAIT_CYC - 1);
  localparam logic [31:0] INIT_LAST = 32'(INIT_WAIT_CYC - 1);

  logic [2:0]  state_q, state_d;
  logic [1:0]  phase_q, phase_d;
  logic [31:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [31:0] work_q, work_d;
  logic [31:0] pend_q, pend_d;
  logic        pend_vld_q, pend_vld_d;
  logic        init_done_q, init_done_d;
  logic [7:0]  lcd_data_q, lcd_data_d;
  logic        lcd_rs_q, lcd_rs_d;
  logic        lcd_en_q, lcd_en_d;

  logic        xfer_done;
  logic        nxt_xfer;
  logic [31:0] wait_last;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    logic [7:0] c;
    case (n)
      4'h0: c = 8'h30;  4'h1: c = 8'h31;  4'h2: c = 8'h32;  4'h3: c = 8'h33;
      4'h4: c = 8'h34;  4'h5: c = 8'h35;  4'h6: c = 8'h36;  4'h7: c = 8'h37;
      4'h8: c = 8'h38;  4'h9: c = 8'h39;  4'hA: c = 8'h41;  4'hB: c = 8'h42;
      4'hC: c = 8'h43;  4'hD: c = 8'h44;  4'hE: c = 8'h45;  default: c = 8'h46;
    endcase
    return c;
  endfunction

  // Byte carried by the transaction for a given state/index/word.
  // Characters go most-significant nibble first: idx 0 -> word[31:28].
  function automatic logic [7:0] xfer_byte(input logic [2:0]  st,
                                           input logic [2:0]  idx,
                                           input logic [31:0] word);
    logic [7:0]  b;
    logic [2:0]  sel;
    logic [31:0] sh;
    b   = 8'h00;
    sel = 3'd7 - idx;
    sh  = word >> {sel, 2'b00};
    case (st)
      ST_INIT: begin
        case (idx)
          3'd0:    b = 8'h38;
          3'd1:    b = 8'h0C;
          3'd2:    b = 8'h01;
          default: b = 8'h06;
        endcase
      end
      ST_ADDR: b = LINE_ADDR;
      ST_CHAR: b = hex_char(sh[3:0]);
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  // Clear Display needs the long settle; the latched bus byte identifies it.
  assign wait_last = (!lcd_rs_q && lcd_data_q == 8'h01) ? CLR_LAST : CMD_LAST;

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    work_d      = work_q;
    pend_d      = pend_q;
    pend_vld_d  = pend_vld_q;
    init_done_d = init_done_q;
    xfer_done   = 1'b0;

    // Shared SETUP -> PULSE -> WAIT timing for every bus byte.
    if (state_q == ST_INIT || state_q == ST_ADDR || state_q == ST_CHAR) begin
      case (phase_q)
        PH_SETUP: begin
          phase_d = PH_PULSE;
          cnt_d   = '0;
        end
        PH_PULSE: begin
          if (cnt_q == EN_LAST) begin
            phase_d = PH_WAIT;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 32'd1;
          end
        end
        default: begin
          if (cnt_q == wait_last) begin
            xfer_done = 1'b1;
            cnt_d     = '0;
          end else begin
            cnt_d = cnt_q + 32'd1;
          end
        end
      endcase
    end

    case (state_q)
      ST_PWR_WAIT: begin
        if (cnt_q == INIT_LAST) begin
          state_d = ST_INIT;
          idx_d   = 3'd0;
          phase_d = PH_SETUP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      ST_INIT: begin
        if (xfer_done) begin
          if (idx_q == 3'd3) begin
            state_d     = ST_IDLE;
            init_done_d = 1'b1;
          end else begin
            idx_d   = idx_q + 3'd1;
            phase_d = PH_SETUP;
          end
        end
      end
      ST_IDLE: begin
        if (msg_valid && init_done_q) begin
          work_d  = msg_data;
          state_d = ST_ADDR;
          phase_d = PH_SETUP;
          cnt_d   = '0;
        end
      end
      ST_ADDR: begin
        if (msg_valid) begin
          pend_d     = msg_data;
          pend_vld_d = 1'b1;
        end
        if (xfer_done) begin
          state_d = ST_CHAR;
          idx_d   = 3'd0;
          phase_d = PH_SETUP;
        end
      end
      ST_CHAR: begin
        if (xfer_done && idx_q == 3'd7) begin
          // Message complete: chain straight into the next one if any value
          // is waiting, so busy never drops between back-to-back messages.
          if (pend_vld_q) begin
            work_d     = pend_q;
            pend_vld_d = msg_valid;
            if (msg_valid) pend_d = msg_data;
            state_d    = ST_ADDR;
            phase_d    = PH_SETUP;
          end else if (msg_valid) begin
            work_d  = msg_data;
            state_d = ST_ADDR;
            phase_d = PH_SETUP;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          if (msg_valid) begin
            pend_d     = msg_data;
            pend_vld_d = 1'b1;
          end
          if (xfer_done) begin
            idx_d   = idx_q + 3'd1;
            phase_d = PH_SETUP;
          end
        end
      end
      default: begin
        state_d = ST_PWR_WAIT;
        cnt_d   = '0;
      end
    endcase

    // Bus outputs are registered from next-state values so they line up
    // exactly with the phase they belong to, and hold through WAIT.
    nxt_xfer   = (state_d == ST_INIT || state_d == ST_ADDR || state_d == ST_CHAR);
    lcd_data_d = lcd_data_q;
    lcd_rs_d   = lcd_rs_q;
    if (nxt_xfer) begin
      lcd_data_d = xfer_byte(state_d, idx_d, work_d);
      lcd_rs_d   = (state_d == ST_CHAR);
    end
    lcd_en_d = nxt_xfer && (phase_d == PH_PULSE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_PWR_WAIT;
      phase_q     <= PH_SETUP;
      cnt_q       <= '0;
      idx_q       <= '0;
      work_q      <= '0;
      pend_q      <= '0;
      pend_vld_q  <= 1'b0;
      init_done_q <= 1'b0;
      lcd_data_q  <= '0;
      lcd_rs_q    <= 1'b0;
      lcd_en_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      work_q      <= work_d;
      pend_q      <= pend_d;
      pend_vld_q  <= pend_vld_d;
      init_done_q <= init_done_d;
      lcd_data_q  <= lcd_data_d;
      lcd_rs_q    <= lcd_rs_d;
      lcd_en_q    <= lcd_en_d;
    end
  end

  assign init_done = init_done_q;
  assign msg_ready = init_done_q;
  assign busy      = (state_q != ST_IDLE);
  assign LCD_DATA  = lcd_data_q;
  assign LCD_RS    = lcd_rs_q;
  assign LCD_EN    = lcd_en_q;
  assign LCD_RW    = 1'b0;
  assign dbg_state = state_q;

endmodule

// File: doc/lcd_hex_sequencer.md
Name: lcd_hex_sequencer

Overview:
Drives a 16x2 HD44780-style character LCD directly from the processor clock domain. After reset it runs the power-on init sequence, then accepts 32-bit words from the datapath (e.g. the register value written by the display instruction). Each accepted word is rendered as 8 uppercase hex ASCII characters at the start of line 1. It owns all LCD bus timing (EN pulse width, command settle times). It holds a one-deep "latest value" pending buffer so that back-to-back display requests never stall the CPU.

Parameters:
EN_HIGH_CYC, 16, clock cycles LCD_EN is held high per bus transaction (>=1)
CMD_WAIT_CYC, 2000, cycles LCD_EN is held low after a normal command or data write (>=1)
CLR_WAIT_CYC, 82000, cycles LCD_EN is held low after the Clear Display command (>=1)
INIT_WAIT_CYC, 1000000, power-up wait before the first command (>=1)
LINE_ADDR, 8'h80, Set-DDRAM-address command issued before each message

Ports:
clk  input  1  system clock; all logic on posedge
reset  input  1  synchronous, active-high reset
msg_valid  input  1  display request strobe, sampled each cycle
msg_data  input  32  word to display, valid with msg_valid
msg_ready  output  1  request will be accepted this cycle (equals init_done)
busy  output  1  high while initialising or writing a message
init_done  output  1  init sequence complete, sticky until reset
LCD_DATA  output  8  LCD data bus
LCD_RW  output  1  read/write select, tied 0 (write only)
LCD_EN  output  1  LCD enable strobe
LCD_RS  output  1  register select: 0 = command, 1 = data

Behaviour:
- Reset (synchronous, any state, including mid-transaction):
  - State goes to PWR_WAIT.
  - Outputs: LCD_DATA=0, LCD_RS=0, LCD_RW=0, LCD_EN=0, init_done=0, msg_ready=0, busy=1.
  - Pending buffer cleared; all counters cleared.
- Bus transaction (XFER), used for every byte:
  - SETUP: 1 cycle, LCD_DATA/LCD_RS driven, EN=0.
  - PULSE: EN=1 for EN_HIGH_CYC cycles.
  - WAIT: EN=0 for CMD_WAIT_CYC cycles, or CLR_WAIT_CYC cycles for byte 8'h01 with RS=0.
  - LCD_DATA and LCD_RS stay stable from SETUP through the end of WAIT.
  - Total length = 1 + EN_HIGH_CYC + wait.
- State sequence:
  - PWR_WAIT: INIT_WAIT_CYC cycles.
  - INIT: four command XFERs in order 8'h38, 8'h0C, 8'h01, 8'h06.
  - Then init_done=1, busy=0, go to IDLE.
  - IDLE -> ADDR: XFER of LINE_ADDR with RS=0.
  - ADDR -> CHAR: 8 data XFERs with RS=1, nibble 7 (msg_data[31:28]) first, down to nibble 0.
  - CHAR -> IDLE.
- Hex encoding: nibble n<10 -> 8'h30+n; n>=10 -> 8'h37+n (uppercase 'A'-'F').
- Handshake:
  - msg_ready = init_done.
  - msg_valid while msg_ready=0 is ignored and not buffered.
  - In IDLE, an accepted msg_valid latches msg_data into the working register. ADDR SETUP begins the next cycle, and busy rises that next cycle.
  - While busy (ADDR/CHAR), an accepted msg_valid writes the pending buffer and sets pending flag. Later writes overwrite it (last value wins). The working register is never disturbed mid-message.
  - On the cycle CHAR finishes:
    - If pending is set, the pending value moves to the working register, pending clears, and ADDR starts next cycle without passing through IDLE (busy stays 1).
    - If msg_valid is also high that same cycle, it goes to pending.
- Same value requested twice: written again (no compare/suppress).
- Message latency: accept-to-last-EN-fall = 9 XFERs; idle-to-idle = 9*(1+EN_HIGH_CYC+CMD_WAIT_CYC) cycles.

Test Plan:
1. Params EN_HIGH_CYC=2, CMD_WAIT_CYC=4, CLR_WAIT_CYC=8, INIT_WAIT_CYC=10. Release reset -> EN pulses carry 38,0C,01,06 with RS=0; gap after 01 is 8 cycles; init_done rises exactly 42 cycles after reset deasserts; msg_valid during init is ignored.
2. After init, send msg_data=32'h1234ABCD -> EN-sampled bytes 80 (RS=0), then 31,32,33,34,41,42,43,44 (RS=1); busy high for 63 cycles; LCD_RW always 0.
3. Send 32'h00000000, then 32'hFFFFFFFF -> first gives eight 8'h30; second gives eight 8'h46.
4. During a message, send 32'hAAAAAAAA then 32'h55555555 -> current message unaffected; the next message (busy never drops) shows 55555555; AAAAAAAA is never displayed.
5. msg_valid on the exact CHAR-completion cycle while pending=0 -> value displayed next with no IDLE gap.
6. Assert reset for 1 cycle mid-CHAR -> next cycle EN=0, DATA=0, init_done=0, pending cleared; full init repeats with timing as in test 1.
